pe_multislot: RTL and testbench

- Parametrised successor to the 8x8 integer PE used in the systolic array. Generic activation/weight widths and a bank of NSLOT weight slots per PE.
- A slot-select command switches the active weight without reloading, including mid-MULT stream.
- Same top-to-bottom command/weight/partial-sum bus and left-to-right activation pass-through. Registered outputs, one-cycle hop latency.

---
 rtl/pe_pkg.sv | 35 +++
 rtl/pe_mac.sv | 42 ++++
 rtl/pe_multislot.sv | 139 +++++++++++++
 tb/tb_pe_multislot.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the multi-slot systolic PE: command codes, one-hot
// state encoding and top/bottom bus field offsets.
package pe_pkg;

  localparam logic [2:0] CMD_RSET = 3'd1;
  localparam logic [2:0] CMD_ALT2 = 3'd2;
  localparam logic [2:0] CMD_INTM = 3'd3;
  localparam logic [2:0] CMD_LOAD = 3'd4;
  localparam logic [2:0] CMD_MULT = 3'd5;
  localparam logic [2:0] CMD_SSEL = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_LOAD = 3'b010,
    ST_MULT = 3'b100
  } state_e;

  function automatic int cmd_lo(input int ww);
    return ww;
  endfunction

  function automatic int slot_lo(input int ww);
    return ww + 3;
  endfunction

  function automatic int idx_lo(input int ww, input int sw);
    return ww + 3 + sw;
  endfunction

  // The flag bit sits above every field, so all fields must fit below NB-1.
  function automatic bit layout_ok(input int nb, input int ww, input int sw, input int nid);
    return (nb - 1) >= (ww + 3 + sw + nid);
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational signed multiply-add for the PE; wraps to OW bits by default,
// clamps to the OW-bit signed range when PE_MULTISLOT_SAT_EN is defined.
module pe_mac #(
  parameter int AW = 8,
  parameter int WW = 8,
  parameter int OW = 26
) (
  input  logic [AW-1:0] a,
  input  logic          mode,
  input  logic [WW-1:0] w,
  input  logic [OW-1:0] bias,
  output logic [OW-1:0] sum
);

  localparam int PW = AW + 1 + WW;
  localparam int FW = ((PW > OW) ? PW : OW) + 1;

  logic signed [AW:0]    a_ext;
  logic signed [WW-1:0]  w_s;
  logic signed [PW-1:0]  prod;
  logic signed [FW-1:0]  full;

  assign a_ext = {a[AW-1] & mode, a};
  assign w_s   = w;
  assign prod  = a_ext * w_s;
  assign full  = {{(FW-PW){prod[PW-1]}}, prod} + {{(FW-OW){bias[OW-1]}}, bias};

`ifdef PE_MULTISLOT_SAT_EN
  // In range exactly when every bit from OW-1 upward matches the sign.
  logic [FW-OW:0] hi;
  assign hi = full[FW-1:OW-1];
  always_comb begin
    sum = full[OW-1:0];
    if (!((&hi) || !(|hi))) begin
      sum = full[FW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
  end
`else
  assign sum = full[OW-1:0];
`endif

endmodule

// File: rtl/pe_multislot.sv
// Systolic PE with NSLOT selectable weight slots. Optional saturating
// accumulate via PE_MULTISLOT_SAT_EN (handled inside pe_mac).
module pe_multislot
  import pe_pkg::*;
#(
  parameter int AW      = 8,
  parameter int WW      = 8,
  parameter int NB      = 27,
  parameter int NID     = 7,
  parameter int NSLOT   = 4,
  parameter int ROW_IDX = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] A_in,
  input  logic [NB-1:0] B_in,
  output logic [AW-1:0] C_out,
  output logic [NB-1:0] D_out
);

  localparam int SW      = $clog2(NSLOT);
  localparam int CMD_LO  = cmd_lo(WW);
  localparam int SLOT_LO = slot_lo(WW);
  localparam int IDX_LO  = idx_lo(WW, SW);

  if (!layout_ok(NB, WW, SW, NID)) begin : g_bad_layout
    $error("pe_multislot: NB too narrow for weight/cmd/slot/idx fields");
  end
  if (NSLOT < 2 || (NSLOT & (NSLOT - 1)) != 0) begin : g_bad_nslot
    $error("pe_multislot: NSLOT must be a power of two >= 2");
  end

  logic           fl;
  logic [2:0]     cmd;
  logic [SW-1:0]  slot_f;
  logic [NID-1:0] idx_f;
  logic [WW-1:0]  wt_f;

  assign fl     = B_in[NB-1];
  assign cmd    = B_in[CMD_LO +: 3];
  assign slot_f = B_in[SLOT_LO +: SW];
  assign idx_f  = B_in[IDX_LO +: NID];
  assign wt_f   = B_in[WW-1:0];

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [SW-1:0] act_q, act_d;
  logic [WW-1:0] slot_q [NSLOT];
  logic          clr, ld_en;
  logic [NB-1:0] d_d;
  logic [NB-2:0] sum;

  // The active slot is read from the register, so an SSEL only affects the next beat.
  pe_mac #(.AW(AW), .WW(WW), .OW(NB-1)) u_mac (
    .a    (A_in),
    .mode (mode_q),
    .w    (slot_q[act_q]),
    .bias (B_in[NB-2:0]),
    .sum  (sum)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    act_d   = act_q;
    d_d     = '0;
    clr     = 1'b0;
    ld_en   = 1'b0;
    if (fl && cmd == CMD_RSET) begin
      clr     = 1'b1;
      state_d = ST_IDLE;
      mode_d  = 1'b0;
      act_d   = '0;
      d_d     = B_in;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fl) begin
            case (cmd)
              CMD_ALT2: begin mode_d = 1'b0; d_d = B_in; end
              CMD_INTM: begin mode_d = 1'b1; d_d = B_in; end
              CMD_LOAD: begin state_d = ST_LOAD; d_d = B_in; end
              CMD_MULT: begin state_d = ST_MULT; d_d = B_in; end
              CMD_SSEL: begin act_d = slot_f; d_d = B_in; end
              default:  d_d = '0;
            endcase
          end
        end
        ST_LOAD: begin
          if (fl && cmd == 3'd0 && idx_f == NID'(ROW_IDX)) begin
            ld_en   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            d_d = B_in;
          end
        end
        ST_MULT: begin
          if (fl && cmd == CMD_ALT2) begin
            state_d = ST_IDLE;
            d_d     = B_in;
          end else if (fl && cmd == CMD_SSEL) begin
            act_d = slot_f;
            d_d   = B_in;
          end else begin
            d_d = {1'b0, sum};
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      act_q   <= '0;
      C_out   <= '0;
      D_out   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      act_q   <= act_d;
      C_out   <= A_in;
      D_out   <= d_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
    end else if (ld_en) begin
      slot_q[slot_f] <= wt_f;
    end
  end

endmodule

// File: tb/tb_pe_multislot.sv
// Directed plus randomized bench for pe_multislot against an arithmetic reference model.
module tb_pe_multislot;

  logic        clk;
  logic        rst_n;
  logic [7:0]  A_in;
  logic [26:0] B_in;
  logic [7:0]  C_out;
  logic [26:0] D_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [34:0] exp_q[$];

  // Reference model state (mode: 1 = signed activations).
  int         m_state;  // 0 idle, 1 load, 2 mult
  bit         m_mode;
  int         m_act;
  logic [7:0] m_slot [4];

  pe_multislot dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A_in  (A_in),
    .B_in  (B_in),
    .C_out (C_out),
    .D_out (D_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [26:0] mk(input bit fl, input logic [2:0] cmd,
                                     input logic [1:0] slot, input logic [6:0] idx,
                                     input logic [7:0] w);
    return {fl, 6'b0, idx, slot, cmd, w};
  endfunction

  function automatic logic [26:0] bias_word(input logic [25:0] b);
    return {1'b0, b};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_mode  = 1'b0;
    m_act   = 0;
    for (int i = 0; i < 4; i++) m_slot[i] = 8'h00;
  endtask

  task automatic model_step(input logic [7:0] a, input logic [26:0] b, output logic [26:0] d);
    bit fl;
    int cmd, slot, idx;
    logic signed [63:0] av, wv, bv, s;
    fl   = b[26];
    cmd  = int'(b[10:8]);
    slot = int'(b[12:11]);
    idx  = int'(b[19:13]);
    d    = 27'd0;
    if (fl && cmd == 1) begin
      model_reset();
      d = b;
    end else if (m_state == 0) begin
      if (fl && cmd >= 2 && cmd <= 6) d = b;
      if (fl && cmd == 2) m_mode = 1'b0;
      if (fl && cmd == 3) m_mode = 1'b1;
      if (fl && cmd == 4) m_state = 1;
      if (fl && cmd == 5) m_state = 2;
      if (fl && cmd == 6) m_act = slot;
    end else if (m_state == 1) begin
      if (fl && cmd == 0 && idx == 0) begin
        m_slot[slot] = b[7:0];
        m_state = 0;
      end else begin
        d = b;
      end
    end else begin
      if (fl && cmd == 2) begin
        m_state = 0;
        d = b;
      end else if (fl && cmd == 6) begin
        m_act = slot;
        d = b;
      end else begin
        av = m_mode ? 64'($signed(a)) : 64'(a);
        wv = 64'($signed(m_slot[m_act]));
        bv = 64'($signed(b[25:0]));
        s  = av * wv + bv;
`ifdef PE_MULTISLOT_SAT_EN
        if (s > 64'sd33554431) s = 64'sd33554431;
        if (s < -64'sd33554432) s = -64'sd33554432;
`endif
        d = {1'b0, s[25:0]};
      end
    end
  endtask

  task automatic chk(input string tag, input logic [26:0] got, input logic [26:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one beat, advance one clock, compare both registered outputs.
  task automatic step(input string tag, input logic [7:0] a, input logic [26:0] b);
    logic [26:0] d;
    logic [34:0] e;
    A_in = a;
    B_in = b;
    model_step(a, b, d);
    exp_q.push_back({a, d});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".C"}, 27'(C_out), 27'(e[34:27]));
    chk({tag, ".D"}, D_out, e[26:0]);
  endtask

  initial begin
    logic [7:0]  ra;
    logic [26:0] rb;
    int          r;

    rst_n = 1'b0;
    A_in  = 8'h00;
    B_in  = 27'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.C", 27'(C_out), 27'd0);
    chk("reset.D", D_out, 27'd0);
    rst_n = 1'b1;

    // Signed activation path.
    step("intm",  8'h11, mk(1, 3'd3, 2'd0, 7'd0, 8'h00));
    step("load",  8'h22, mk(1, 3'd4, 2'd0, 7'd0, 8'h00));
    step("wt2",   8'h33, mk(1, 3'd0, 2'd2, 7'd0, 8'hFD));
    step("ssel2", 8'h44, mk(1, 3'd6, 2'd2, 7'd0, 8'h00));
    step("mult",  8'h55, mk(1, 3'd5, 2'd0, 7'd0, 8'h00));
    step("mac_int", 8'h80, bias_word(26'd5));
    chk("mac_int_const", D_out, 27'd389);

    // Unsigned activation path.
    step("alt2_exit", 8'h01, mk(1, 3'd2, 2'd0, 7'd0, 8'h00));
    step("alt2",  8'h02, mk(1, 3'd2, 2'd0, 7'd0, 8'h00));
    step("load_u", 8'h03, mk(1, 3'd4, 2'd0, 7'd0, 8'h00));
    step("wt2_u", 8'h04, mk(1, 3'd0, 2'd2, 7'd0, 8'hFD));
    step("ssel2_u", 8'h05, mk(1, 3'd6, 2'd2, 7'd0, 8'h00));
    step("mult_u", 8'h06, mk(1, 3'd5, 2'd0, 7'd0, 8'h00));
    step("mac_uint", 8'h80, bias_word(26'd5));
    chk("mac_uint_const", D_out, 27'h3FFFE85);
    step("alt2_exit_u", 8'h07, mk(1, 3'd2, 2'd0, 7'd0, 8'h00));

    // Load addressed to another row is forwarded; matching one is consumed.
    step("load2", 8'hA0, mk(1, 3'd4, 2'd0, 7'd0, 8'h00));
    step("wt_other_row", 8'hA1, mk(1, 3'd0, 2'd1, 7'd1, 8'h5A));
    chk("wt_other_row_const", D_out, mk(1, 3'd0, 2'd1, 7'd1, 8'h5A));
    step("load_ctrl_fwd", 8'hA2, mk(1, 3'd5, 2'd0, 7'd0, 8'h00));
    step("wt_s0", 8'hA3, mk(1, 3'd0, 2'd0, 7'd0, 8'h02));
    chk("wt_s0_const", D_out, 27'd0);
    step("load3", 8'hA4, mk(1, 3'd4, 2'd0, 7'd0, 8'h00));
    step("wt_s1", 8'hA5, mk(1, 3'd0, 2'd1, 7'd0, 8'hFF));
    step("ssel0", 8'hA6, mk(1, 3'd6, 2'd0, 7'd0, 8'h00));

    // Slot switch mid-MULT stream (mode still uint here).
    step("mult2", 8'h00, mk(1, 3'd5, 2'd0, 7'd0, 8'h00));
    step("mac_s0", 8'd10, bias_word(26'd0));
    chk("mac_s0_const", D_out, 27'd20);
    step("ssel1_mult", 8'd10, mk(1, 3'd6, 2'd1, 7'd0, 8'h00));
    step("mac_s1", 8'd10, bias_word(26'd0));
    chk("mac_s1_const", D_out, 27'h3FFFFF6);
    step("alt2_exit2", 8'd0, mk(1, 3'd2, 2'd0, 7'd0, 8'h00));
    step("idle_plain", 8'd9, bias_word(26'd77));
    chk("idle_plain_const", D_out, 27'd0);

    // Bias at the top of the range: wraps or clamps.
    step("load4", 8'h00, mk(1, 3'd4, 2'd0, 7'd0, 8'h00));
    step("wt_s3", 8'h00, mk(1, 3'd0, 2'd3, 7'd0, 8'h01));
    step("ssel3", 8'h00, mk(1, 3'd6, 2'd3, 7'd0, 8'h00));
    step("mult3", 8'h00, mk(1, 3'd5, 2'd0, 7'd0, 8'h00));
    step("mac_edge", 8'd1, bias_word(26'h1FFFFFF));
`ifdef PE_MULTISLOT_SAT_EN
    chk("mac_edge_const", D_out, 27'h1FFFFFF);
`else
    chk("mac_edge_const", D_out, 27'h2000000);
`endif

    // Asynchronous reset between clock edges while in MULT.
    step("mac_pre_rst", 8'd3, bias_word(26'd7));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.C", 27'(C_out), 27'd0);
    chk("async_rst.D", D_out, 27'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst_plain", 8'd5, bias_word(26'd123));
    chk("post_rst_plain_const", D_out, 27'd0);

    // Randomized command/data mix.
    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom);
      r  = $urandom_range(0, 11);
      case (r)
        0: rb = mk(1, 3'd4, 2'd0, 7'd0, 8'($urandom));
        1: rb = mk(1, 3'd0, 2'($urandom), 7'($urandom_range(0, 1)), 8'($urandom));
        2: rb = mk(1, 3'd5, 2'd0, 7'd0, 8'h00);
        3: rb = mk(1, 3'd2, 2'd0, 7'd0, 8'h00);
        4: rb = mk(1, 3'd3, 2'd0, 7'd0, 8'h00);
        5: rb = mk(1, 3'd6, 2'($urandom), 7'd0, 8'h00);
        6: rb = ($urandom_range(0, 7) == 0) ? mk(1, 3'd1, 2'd0, 7'd0, 8'h00) : bias_word(26'($urandom));
        7: rb = mk(1, 3'd7, 2'($urandom), 7'($urandom), 8'($urandom));
        default: rb = bias_word(26'($urandom));
      endcase
      step("rand", ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
